// File: rtl/ttl_bus_pkg.sv
// Shared constants and helpers for the TTL bus receiver slice.
// Optional feature macro used by the receiver: BUS_FLOAT_CHECK_EN.
package ttl_bus_pkg;

  localparam int BUS_WIDTH_DEFAULT  = 8;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  // Per-cycle decisions taken by the receiver at each Clk rise.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } load_ctrl_t;

  // Ceiling log2, never below 1 so that pointer vectors stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/ttl_bus_rx_fifo.sv
// Receive FIFO: storage, wrapping pointers, occupancy count, Full, and the
// registered head-of-queue output stage (no write-to-read bypass).
module ttl_bus_rx_fifo
  import ttl_bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    held;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Entries already in storage after this edge's pop; this edge's write is not visible yet.
    held         = pop ? (count_q - CW'(1)) : count_q;
    dout_valid_d = (held != '0);
    dout_d       = dout_valid_d ? mem[rd_d] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/ttl_bus_receiver.sv
// Receiving end of the shared tri-state bus: load strobe, FIFO handshake, Ovr/Float flags.
// Define BUS_FLOAT_CHECK_EN to flag and zero Z/X bits sampled from the bus.
module ttl_bus_receiver
  import ttl_bus_pkg::*;
#(
  parameter int WIDTH      = BUS_WIDTH_DEFAULT,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic [WIDTH-1:0] D,
  input  logic             LD_bar,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid,
  input  logic             Q_ready,
  output logic             Full,
  output logic             Ovr,
  input  logic             Ovr_clr,
  output logic             Float
);

  load_ctrl_t       ctrl;
  logic [WIDTH-1:0] d_store;
  logic [WIDTH-1:0] q_int;
  logic             q_valid_int;
  logic             full_int;
  logic             ovr_q, ovr_d;
  logic             float_q;

  always_comb begin
    ctrl      = '0;
    ctrl.pop  = q_valid_int && Q_ready;
    ctrl.push = !LD_bar && (!full_int || ctrl.pop);
    ctrl.drop = !LD_bar && full_int && !ctrl.pop;
  end

  // A coincident overrun beats the clear request.
  always_comb begin
    ovr_d = ovr_q;
    if (ctrl.drop)    ovr_d = 1'b1;
    else if (Ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) ovr_q <= 1'b0;
    else            ovr_q <= ovr_d;
  end

`ifdef BUS_FLOAT_CHECK_EN
  logic float_d;
  logic bus_has_float;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sanitize
    assign d_store[gi] = (D[gi] === 1'b1);
  end

  assign bus_has_float = $isunknown(D);

  always_comb begin
    float_d = float_q | (ctrl.push & bus_has_float);
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) float_q <= 1'b0;
    else            float_q <= float_d;
  end

  always_ff @(posedge Clk) begin
    if (Clear_bar && ctrl.push && bus_has_float)
      $display("%0t ttl_bus_receiver: floating bus sampled, D=%b", $time, D);
  end
`else
  assign d_store = D;
  assign float_q = 1'b0;
`endif

  ttl_bus_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Clear_bar),
    .push       (ctrl.push),
    .pop        (ctrl.pop),
    .din        (d_store),
    .dout       (q_int),
    .dout_valid (q_valid_int),
    .full       (full_int)
  );

  // Board-level propagation delays only exist in simulation models with non-zero settings.
  if ((DELAY_RISE == 0) && (DELAY_FALL == 0)) begin : g_out_direct
    assign Q       = q_int;
    assign Q_valid = q_valid_int;
    assign Full    = full_int;
    assign Ovr     = ovr_q;
    assign Float   = float_q;
  end else begin : g_out_delayed
    assign #(DELAY_RISE, DELAY_FALL) Q       = q_int;
    assign #(DELAY_RISE, DELAY_FALL) Q_valid = q_valid_int;
    assign #(DELAY_RISE, DELAY_FALL) Full    = full_int;
    assign #(DELAY_RISE, DELAY_FALL) Ovr     = ovr_q;
    assign #(DELAY_RISE, DELAY_FALL) Float   = float_q;
  end

endmodule

// File: tb/tb_ttl_bus_receiver.sv
// Self-checking bench for ttl_bus_receiver: queue-based reference model compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_ttl_bus_receiver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             Clk;
  logic             Clear_bar;
  logic [WIDTH-1:0] D;
  logic             LD_bar;
  logic [WIDTH-1:0] Q;
  logic             Q_valid;
  logic             Q_ready;
  logic             Full;
  logic             Ovr;
  logic             Ovr_clr;
  logic             Float;

  int errors = 0;
  int checks = 0;

  ttl_bus_receiver #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) dut (
    .Clk       (Clk),
    .Clear_bar (Clear_bar),
    .D         (D),
    .LD_bar    (LD_bar),
    .Q         (Q),
    .Q_valid   (Q_valid),
    .Q_ready   (Q_ready),
    .Full      (Full),
    .Ovr       (Ovr),
    .Ovr_clr   (Ovr_clr),
    .Float     (Float)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; the output register shows the head
  // that was already stored before the current edge.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q;
  bit               m_valid;
  bit               m_ovr;
  bit               m_float;

  always @(posedge Clk or negedge Clear_bar) begin
    bit               pop;
    bit               push;
    bit               drop;
    logic [WIDTH-1:0] stored;
    if (!Clear_bar) begin
      mq.delete();
      m_q     = '0;
      m_valid = 0;
      m_ovr   = 0;
      m_float = 0;
    end else begin
      pop  = m_valid && (Q_ready === 1'b1);
      push = (LD_bar === 1'b0) && ((mq.size() < DEPTH) || pop);
      drop = (LD_bar === 1'b0) && !push;
      if (pop) void'(mq.pop_front());
      if (mq.size() > 0) begin
        m_valid = 1;
        m_q     = mq[0];
      end else begin
        m_valid = 0;
      end
      if (push) begin
        stored = D;
`ifdef BUS_FLOAT_CHECK_EN
        if ($isunknown(D)) m_float = 1;
        for (int i = 0; i < WIDTH; i++) stored[i] = (D[i] === 1'b1);
`endif
        mq.push_back(stored);
      end
      if (drop) m_ovr = 1;
      else if (Ovr_clr === 1'b1) m_ovr = 0;
    end
  end

  always @(negedge Clk) begin
    check("model_Q",       32'(Q),       32'(m_q));
    check("model_Q_valid", 32'(Q_valid), 32'(m_valid));
    check("model_Full",    32'(Full),    32'(mq.size() == DEPTH));
    check("model_Ovr",     32'(Ovr),     32'(m_ovr));
    check("model_Float",   32'(Float),   32'(m_float));
    $display("cycle t=%0t ld_n=%b d=%h rdy=%b clr=%b -> Q=%h V=%b F=%b O=%b Fl=%b",
             $time, LD_bar, D, Q_ready, Ovr_clr, Q, Q_valid, Full, Ovr, Float);
  end

  // Apply inputs right after a falling edge, return at the next falling edge.
  task automatic step(input logic ld_n, input logic [WIDTH-1:0] d, input logic rdy, input logic oclr);
    LD_bar  = ld_n;
    D       = d;
    Q_ready = rdy;
    Ovr_clr = oclr;
    @(negedge Clk);
  endtask

  logic [WIDTH-1:0] zv;

  initial begin
    zv        = 8'bzzzz_1010;
    Clear_bar = 1'b0;
    D         = 8'hA5;
    LD_bar    = 1'b0;
    Q_ready   = 1'b0;
    Ovr_clr   = 1'b0;

    // 1: held in reset with a load strobe active
    repeat (3) @(negedge Clk);
    check("rst_Q",       32'(Q),       32'h00);
    check("rst_Q_valid", 32'(Q_valid), 32'h0);
    check("rst_Full",    32'(Full),    32'h0);
    check("rst_Ovr",     32'(Ovr),     32'h0);
    check("rst_Float",   32'(Float),   32'h0);
    Clear_bar = 1'b1;
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("idle_Q_valid", 32'(Q_valid), 32'h0);

    // 2: single load, latency one cycle after storage, then one pop
    step(1'b0, 8'h3C, 1'b0, 1'b0);
    check("t2_latency_valid", 32'(Q_valid), 32'h0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("t2_Q_valid", 32'(Q_valid), 32'h1);
    check("t2_Q",       32'(Q),       32'h3C);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t2_pop_valid", 32'(Q_valid), 32'h0);
    check("t2_Q_retained", 32'(Q),      32'h3C);

    // 3: three back-to-back loads into a two-entry FIFO
    step(1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h22, 1'b0, 1'b0);
    check("t3_Full", 32'(Full), 32'h1);
    check("t3_Ovr_before", 32'(Ovr), 32'h0);
    step(1'b0, 8'h33, 1'b0, 1'b0);
    check("t3_Ovr",  32'(Ovr),  32'h1);
    check("t3_head", 32'(Q),    32'h11);

    // 5a: plain clear of Ovr
    step(1'b1, 8'h00, 1'b0, 1'b1);
    check("t5_Ovr_cleared", 32'(Ovr), 32'h0);

    // 4: load while full with a simultaneous pop
    step(1'b0, 8'h44, 1'b1, 1'b0);
    check("t4_Full", 32'(Full), 32'h1);
    check("t4_Ovr",  32'(Ovr),  32'h0);
    check("t4_Q",    32'(Q),    32'h22);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t4_Q_next", 32'(Q),    32'h44);
    check("t4_Full_dn", 32'(Full), 32'h0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t4_empty", 32'(Q_valid), 32'h0);

    // 5b: clear request coincident with a dropped load
    step(1'b0, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h77, 1'b0, 1'b1);
    check("t5_set_wins", 32'(Ovr), 32'h1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    check("t5_clear", 32'(Ovr), 32'h0);
    check("t5_head",  32'(Q),   32'h55);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t5_pop66", 32'(Q), 32'h66);
    step(1'b1, 8'h00, 1'b1, 1'b0);

    // 6: partially floating bus
    step(1'b0, zv, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("t6_Q_valid", 32'(Q_valid), 32'h1);
`ifdef BUS_FLOAT_CHECK_EN
    check("t6_Float", 32'(Float), 32'h1);
    check("t6_Q",     32'(Q),     32'h0A);
`else
    check("t6_Float", 32'(Float), 32'h0);
    check("t6_Q",     32'(Q),     32'(zv));
`endif

    // Mixed traffic pattern, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      step(logic'((i % 3) == 2), 8'(8'h80 + i * 7), logic'((i % 4) != 1), logic'((i % 11) == 0));
    end

    // Async reset in the middle of traffic
    step(1'b0, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'hAA, 1'b0, 1'b0);
    #2 Clear_bar = 1'b0;
    #1;
    check("async_Q_valid", 32'(Q_valid), 32'h0);
    check("async_Q",       32'(Q),       32'h00);
    check("async_Full",    32'(Full),    32'h0);
    @(negedge Clk);
    Clear_bar = 1'b1;
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("post_rst_valid", 32'(Q_valid), 32'h0);
    check("post_rst_Ovr",   32'(Ovr),     32'h0);
    step(1'b0, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("post_rst_Q", 32'(Q), 32'h5A);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
